// File: rtl/mmio_addr_decoder_if.sv
// CPU data port / slave bus bundle for mmio_addr_decoder.
// master = CPU plus slave-side sources (ready, read data); slave = the decoder itself.
interface mmio_addr_decoder_if #(
   parameter int NUM_SLV = 3,
   parameter int AW      = 32,
   parameter int DW      = 32
);
   logic                   req;
   logic                   we;
   logic [AW-1:0]          addr;
   logic [NUM_SLV-1:0]     slv_rdy;
   logic [NUM_SLV*DW-1:0]  rdata_in;
   logic                   err_clr;
   logic [NUM_SLV-1:0]     slv_sel;
   logic [NUM_SLV-1:0]     slv_we;
   logic                   ack;
   logic                   stall;
   logic [DW-1:0]          rdata_out;
   logic                   bus_err;
   logic [AW-1:0]          err_addr;
   logic [7:0]             err_cnt;

   modport master (
      output req, we, addr, slv_rdy, rdata_in, err_clr,
      input  slv_sel, slv_we, ack, stall, rdata_out, bus_err, err_addr, err_cnt
   );

   modport slave (
      input  req, we, addr, slv_rdy, rdata_in, err_clr,
      output slv_sel, slv_we, ack, stall, rdata_out, bus_err, err_addr, err_cnt
   );
endinterface

// File: rtl/mmio_addr_decoder.sv
// MMIO base/mask decoder with ready/stall handshake, read-return mux and sticky bus error.
// Optional wait timeout enabled by defining MMIO_DEC_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | decode the CPU request; fast slaves and misses complete here
// S_WAIT | hold latched select until the slave is ready (or the timeout fires)
module mmio_addr_decoder #(
   parameter int                     NUM_SLV = 3,
   parameter int                     AW      = 32,
   parameter int                     DW      = 32,
   parameter logic [NUM_SLV*AW-1:0]  BASE    = {32'h900, 32'h800, 32'h000},
   parameter logic [NUM_SLV*AW-1:0]  MASK    = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FF00},
   parameter int                     TIMEOUT = 15
) (
   input logic                   clk,
   input logic                   rst,
   mmio_addr_decoder_if.slave    bus
);

   localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   if (NUM_SLV < 1 || NUM_SLV > 8) begin : g_bad_num_slv
      $error("mmio_addr_decoder: NUM_SLV out of range");
   end
   if (TIMEOUT < 4 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mmio_addr_decoder: TIMEOUT out of range");
   end

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   lat_idx_q, lat_idx_d;
   logic            lat_we_q, lat_we_d;
   logic            rd_vld_q, rd_vld_d;
   logic [IW-1:0]   rd_idx_q, rd_idx_d;
   logic            bus_err_q, bus_err_d;
   logic [AW-1:0]   err_addr_q, err_addr_d;
   logic [7:0]      err_cnt_q, err_cnt_d;
`ifdef MMIO_DEC_TIMEOUT_EN
   localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
   logic [AW-1:0]   lat_addr_q, lat_addr_d;
   logic [7:0]      wait_cnt_q, wait_cnt_d;
`endif

   logic            dec_hit;
   logic [IW-1:0]   dec_idx;
   logic            sel_act;
   logic [IW-1:0]   sel_idx;
   logic            sel_we;
   logic            ack;
   logic            stall;
   logic            err_set;
   logic [AW-1:0]   err_addr_new;
   logic            rd_ack;
   logic            rd_vld;

   // Scan high to low so the lowest matching window wins on overlap.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if ((bus.addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
            dec_hit = 1'b1;
            dec_idx = IW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         lat_idx_q  <= '0;
         lat_we_q   <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_idx_q   <= '0;
         bus_err_q  <= 1'b0;
         err_addr_q <= '0;
         err_cnt_q  <= '0;
`ifdef MMIO_DEC_TIMEOUT_EN
         lat_addr_q <= '0;
         wait_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         lat_idx_q  <= lat_idx_d;
         lat_we_q   <= lat_we_d;
         rd_vld_q   <= rd_vld_d;
         rd_idx_q   <= rd_idx_d;
         bus_err_q  <= bus_err_d;
         err_addr_q <= err_addr_d;
         err_cnt_q  <= err_cnt_d;
`ifdef MMIO_DEC_TIMEOUT_EN
         lat_addr_q <= lat_addr_d;
         wait_cnt_q <= wait_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      lat_idx_d  = lat_idx_q;
      lat_we_d   = lat_we_q;
      rd_vld_d   = rd_vld_q;
      rd_idx_d   = rd_idx_q;
      bus_err_d  = bus_err_q;
      err_addr_d = err_addr_q;
      err_cnt_d  = err_cnt_q;
`ifdef MMIO_DEC_TIMEOUT_EN
      lat_addr_d = lat_addr_q;
      wait_cnt_d = '0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (stall) begin
               state_d   = S_WAIT;
               lat_idx_d = dec_idx;
               lat_we_d  = bus.we;
`ifdef MMIO_DEC_TIMEOUT_EN
               lat_addr_d = bus.addr;
               wait_cnt_d = 8'd1;
`endif
            end
         end
         S_WAIT: begin
            if (ack) begin
               state_d = S_IDLE;
            end
`ifdef MMIO_DEC_TIMEOUT_EN
            else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (rd_ack) begin
         rd_vld_d = rd_vld;
         rd_idx_d = sel_idx;
      end

      // A new error outranks err_clr and re-captures the address.
      if (err_set) begin
         bus_err_d = 1'b1;
         if (!bus_err_q || bus.err_clr) begin
            err_addr_d = err_addr_new;
         end
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end else if (bus.err_clr) begin
         bus_err_d  = 1'b0;
         err_addr_d = '0;
      end
   end

   always_comb begin
      sel_act      = 1'b0;
      sel_idx      = lat_idx_q;
      sel_we       = lat_we_q;
      ack          = 1'b0;
      stall        = 1'b0;
      err_set      = 1'b0;
      err_addr_new = bus.addr;
      rd_ack       = 1'b0;
      rd_vld       = 1'b0;
      if (!rst) begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.req) begin
                  if (dec_hit) begin
                     sel_act = 1'b1;
                     sel_idx = dec_idx;
                     sel_we  = bus.we;
                     ack     = bus.slv_rdy[dec_idx];
                     stall   = !bus.slv_rdy[dec_idx];
                     rd_vld  = 1'b1;
                  end else begin
                     ack     = 1'b1;
                     err_set = 1'b1;
                  end
                  rd_ack = ack & !bus.we;
               end
            end
            S_WAIT: begin
               if (bus.slv_rdy[lat_idx_q]) begin
                  sel_act = 1'b1;
                  ack     = 1'b1;
                  rd_vld  = 1'b1;
                  rd_ack  = !lat_we_q;
               end
`ifdef MMIO_DEC_TIMEOUT_EN
               else if (wait_cnt_q == TO_CNT) begin
                  ack          = 1'b1;
                  err_set      = 1'b1;
                  err_addr_new = lat_addr_q;
                  rd_ack       = !lat_we_q;
               end
`endif
               else begin
                  sel_act = 1'b1;
                  stall   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.slv_sel   = sel_act ? (NUM_SLV'(1) << sel_idx) : '0;
   assign bus.slv_we    = bus.slv_sel & {NUM_SLV{sel_we}};
   assign bus.ack       = ack;
   assign bus.stall     = stall;
   assign bus.rdata_out = rd_vld_q ? bus.rdata_in[int'(rd_idx_q)*DW +: DW] : '0;
   assign bus.bus_err   = bus_err_q;
   assign bus.err_addr  = err_addr_q;
   assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mmio_addr_decoder.sv
// Directed bench for mmio_addr_decoder; read data checked through an expected-value queue.
module tb_mmio_addr_decoder;
   localparam int NS = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   mmio_addr_decoder_if #(.NUM_SLV(NS), .AW(AW), .DW(DW)) bus ();

   mmio_addr_decoder #(
      .NUM_SLV(NS), .AW(AW), .DW(DW),
      .BASE({32'h900, 32'h800, 32'h000}),
      .MASK({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FF00}),
      .TIMEOUT(15)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      logic [DW-1:0] e;
      chk({tag, "_sb_depth"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(tag, bus.rdata_out, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   initial begin
      int stalled;
      rst          = 1'b1;
      bus.req      = 1'b0;
      bus.we       = 1'b0;
      bus.addr     = '0;
      bus.slv_rdy  = 3'b111;
      bus.rdata_in = {32'hCCCC_0002, 32'hBBBB_0001, 32'h1234_5678};
      bus.err_clr  = 1'b0;

      tick(); tick();
      samp();
      chk("rst_ack", bus.ack, 0);
      chk("rst_stall", bus.stall, 0);
      chk("rst_sel", bus.slv_sel, 0);
      chk("rst_rdata", bus.rdata_out, 0);
      chk("rst_err", bus.bus_err, 0);
      chk("rst_cnt", bus.err_cnt, 0);

      // fast read slot 0
      tick(); rst = 1'b0; bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10;
      exp_q.push_back(32'h1234_5678);
      samp();
      chk("fast_sel", bus.slv_sel, 3'b001);
      chk("fast_ack", bus.ack, 1);
      chk("fast_stall", bus.stall, 0);
      tick(); bus.req = 1'b0;
      samp();
      pop_chk("fast_rdata");
      chk("idle_ack", bus.ack, 0);

      // slow write slot 1: ready after 3 cycles
      tick(); bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h804; bus.slv_rdy = 3'b101;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) bus.slv_rdy = 3'b111;
         samp();
         chk($sformatf("slow_we_c%0d", c), bus.slv_we, 3'b010);
         chk($sformatf("slow_stall_c%0d", c), bus.stall, 32'(c < 3));
         chk($sformatf("slow_ack_c%0d", c), bus.ack, 32'(c == 3));
         tick();
      end
      bus.req = 1'b0; bus.we = 1'b0;
      samp();
      chk("rdata_hold", bus.rdata_out, 32'h1234_5678);

      // two unmapped reads back to back
      tick(); bus.req = 1'b1; bus.addr = 32'hA00;
      exp_q.push_back(32'h0);
      samp();
      chk("miss_ack", bus.ack, 1);
      chk("miss_sel", bus.slv_sel, 0);
      tick(); bus.addr = 32'hB00;
      exp_q.push_back(32'h0);
      samp();
      pop_chk("miss_rdata");
      chk("miss_err", bus.bus_err, 1);
      chk("miss_addr", bus.err_addr, 32'hA00);
      chk("miss_cnt", bus.err_cnt, 1);
      chk("miss2_ack", bus.ack, 1);
      tick(); bus.req = 1'b0;
      samp();
      pop_chk("miss2_rdata");
      chk("miss2_addr", bus.err_addr, 32'hA00);
      chk("miss2_cnt", bus.err_cnt, 2);

      // err_clr coincident with a new miss
      tick(); bus.err_clr = 1'b1; bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'hC00;
      samp();
      chk("clrmiss_ack", bus.ack, 1);
      tick(); bus.err_clr = 1'b0; bus.req = 1'b0; bus.we = 1'b0;
      samp();
      chk("clrmiss_err", bus.bus_err, 1);
      chk("clrmiss_addr", bus.err_addr, 32'hC00);
      chk("clrmiss_cnt", bus.err_cnt, 3);
      tick(); bus.err_clr = 1'b1;
      tick(); bus.err_clr = 1'b0;
      samp();
      chk("clr_err", bus.bus_err, 0);
      chk("clr_addr", bus.err_addr, 0);
      chk("clr_cnt", bus.err_cnt, 3);

      // fast read slot 1
      tick(); bus.req = 1'b1; bus.addr = 32'h808;
      exp_q.push_back(32'hBBBB_0001);
      samp();
      chk("s1_sel", bus.slv_sel, 3'b010);
      chk("s1_ack", bus.ack, 1);
      tick(); bus.req = 1'b0;
      samp();
      pop_chk("s1_rdata");

      // slot 2 never ready
      tick(); bus.req = 1'b1; bus.addr = 32'h904; bus.slv_rdy = 3'b011;
`ifdef MMIO_DEC_TIMEOUT_EN
      exp_q.push_back(32'h0);
      for (int c = 0; c < 16; c++) begin
         samp();
         if (c < 15) begin
            chk($sformatf("to_stall_c%0d", c), bus.stall, 1);
            chk($sformatf("to_ack_c%0d", c), bus.ack, 0);
         end else begin
            chk("to_ack", bus.ack, 1);
            chk("to_stall", bus.stall, 0);
            chk("to_sel", bus.slv_sel, 0);
         end
         tick();
      end
      bus.req = 1'b0; bus.slv_rdy = 3'b111;
      samp();
      pop_chk("to_rdata");
      chk("to_err", bus.bus_err, 1);
      chk("to_addr", bus.err_addr, 32'h904);
      chk("to_cnt", bus.err_cnt, 4);
`else
      stalled = 0;
      for (int c = 0; c < 120; c++) begin
         samp();
         if (bus.stall && !bus.ack && bus.slv_sel == 3'b100) stalled++;
         tick();
      end
      chk("nto_stalled", stalled, 120);
      bus.slv_rdy = 3'b111;
      exp_q.push_back(32'hCCCC_0002);
      samp();
      chk("nto_ack", bus.ack, 1);
      chk("nto_sel", bus.slv_sel, 3'b100);
      tick(); bus.req = 1'b0;
      samp();
      pop_chk("nto_rdata");
      chk("nto_err", bus.bus_err, 0);
`endif

      // reset while waiting
      tick(); bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h800; bus.slv_rdy = 3'b101;
      samp();
      chk("rw_stall", bus.stall, 1);
      tick(); rst = 1'b1;
      samp();
      chk("rw_noack", bus.ack, 0);
      tick(); rst = 1'b0; bus.req = 1'b0; bus.we = 1'b0; bus.slv_rdy = 3'b111;
      samp();
      chk("rw_ack", bus.ack, 0);
      chk("rw_stall0", bus.stall, 0);
      chk("rw_sel", bus.slv_sel, 0);
      chk("rw_we", bus.slv_we, 0);
      chk("rw_rdata", bus.rdata_out, 0);
      chk("rw_err", bus.bus_err, 0);
      chk("rw_cnt", bus.err_cnt, 0);

      // back-to-back fast reads after reset
      tick(); bus.req = 1'b1; bus.addr = 32'h004;
      exp_q.push_back(32'h1234_5678);
      samp();
      chk("b2b0_ack", bus.ack, 1);
      tick(); bus.addr = 32'h808;
      exp_q.push_back(32'hBBBB_0001);
      samp();
      pop_chk("b2b0_rdata");
      chk("b2b1_sel", bus.slv_sel, 3'b010);
      tick(); bus.req = 1'b0;
      samp();
      pop_chk("b2b1_rdata");

      // error counter saturation
      tick(); bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'hF00;
      for (int c = 0; c < 260; c++) tick();
      bus.req = 1'b0; bus.we = 1'b0;
      samp();
      chk("sat_cnt", bus.err_cnt, 255);
      chk("sat_addr", bus.err_addr, 32'hF00);

      chk("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
